// File: rtl/uart_pkg.sv
// Shared types and bit-timing helpers for the Arduino UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    function automatic int clksPerBit(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

    // Keep at least one bit so tiny bit periods still give a legal vector.
    function automatic int cntWidth(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an idle-high asynchronous input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/arduino_uart_rx.sv
// 8N1 UART receiver holding the last good command byte from an Arduino.
module arduino_uart_rx
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          BAUD      = 9600,
    parameter logic [7:0]  RESET_CMD = 8'hAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] arduino_command,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = cntWidth(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    logic             rxSync;
    logic             rxPrev_q;
    state_t           state_q;
    logic [CNT_W-1:0] clkCnt_q;
    logic [2:0]       bitIdx_q;
    logic [7:0]       shiftReg_q;
    logic [7:0]       cmd_q;
    logic             cmdValid_q;
    logic             frameErr_q;

    sync_2ff uSync (
        .clk (clk),
        .rst (rst),
        .d_i (uart_rx),
        .q_o (rxSync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rxPrev_q   <= 1'b1;
            clkCnt_q   <= '0;
            bitIdx_q   <= '0;
            shiftReg_q <= '0;
            cmd_q      <= RESET_CMD;
            cmdValid_q <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            rxPrev_q   <= rxSync;
            cmdValid_q <= 1'b0;
            frameErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rxPrev_q && !rxSync) begin
                        state_q  <= START;
                        clkCnt_q <= '0;
                    end
                end
                // A start bit that is high again at mid-bit was only a glitch.
                START: begin
                    if (clkCnt_q == HALF_END) begin
                        clkCnt_q <= '0;
                        bitIdx_q <= '0;
                        state_q  <= rxSync ? IDLE : DATA;
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (clkCnt_q == BIT_END) begin
                        clkCnt_q   <= '0;
                        shiftReg_q <= {rxSync, shiftReg_q[7:1]};
                        bitIdx_q   <= bitIdx_q + 1'b1;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (clkCnt_q == BIT_END) begin
                        clkCnt_q <= '0;
                        if (rxSync) begin
                            cmd_q      <= shiftReg_q;
                            cmdValid_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            frameErr_q <= 1'b1;
                            state_q    <= RECOVER;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                // A held-low line (break) must not be mistaken for a new start bit.
                RECOVER: begin
                    if (rxSync) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arduino_command = cmd_q;
    assign cmd_valid       = cmdValid_q;
    assign frame_err       = frameErr_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_arduino_uart_rx.sv
// Self-checking bench for arduino_uart_rx using a shortened bit period.
module tb_arduino_uart_rx;
    import uart_pkg::*;

    localparam int TB_CLK_FREQ = 50_000_000;
    localparam int TB_BAUD     = 1_562_500;
    localparam int CPB         = 32;
    localparam int GLITCH_CLKS = 6;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       expErr;
        logic [7:0] expCmd;
    } vector_t;

    typedef struct {
        logic       expErr;
        logic [7:0] expCmd;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] arduino_command;
    logic       cmd_valid;
    logic       frame_err;
    logic       busy;

    expect_t expQ[$];
    expect_t popped;
    vector_t vecs[5];
    vector_t v;
    int      nApplied = 0;
    int      nMiscompare = 0;
    int      validCount = 0;
    int      errCount = 0;
    bit      seen3C = 1'b0;

    arduino_uart_rx #(
        .CLK_FREQ  (TB_CLK_FREQ),
        .BAUD      (TB_BAUD),
        .RESET_CMD (8'hAA)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_rx         (uart_rx),
        .arduino_command (arduino_command),
        .cmd_valid       (cmd_valid),
        .frame_err       (frame_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveBits(input logic level, input int clocks);
        uart_rx = level;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        driveBits(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            driveBits(data[i], CPB);
        end
        driveBits(stopBit, CPB);
    endtask

    task automatic applyStimulus(input vector_t vec);
        expect_t e;
        e.expErr = vec.expErr;
        e.expCmd = vec.expCmd;
        expQ.push_back(e);
        sendFrame(vec.data, vec.stopBit);
    endtask

    // Every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (arduino_command == 8'h3C) seen3C = 1'b1;
            if (cmd_valid || frame_err) begin
                checkOutput("pulse_exclusive", 16'(cmd_valid & frame_err), 16'd0);
                if (expQ.size() == 0) begin
                    nApplied++;
                    nMiscompare++;
                    $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b cmd=0x%02h, expected no pulse",
                             cmd_valid, frame_err, arduino_command);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("pulse_kind_err", 16'(frame_err), 16'(popped.expErr));
                    checkOutput("pulse_cmd", 16'(arduino_command), 16'(popped.expCmd));
                end
                if (cmd_valid) validCount++;
                if (frame_err) errCount++;
            end
        end
    end

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
        vecs[3] = '{8'h81, 1'b1, 1'b0, 8'h81};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 8'h81};

        repeat (4) @(negedge clk);
        checkOutput("reset_cmd", 16'(arduino_command), 16'h00AA);
        checkOutput("reset_valid", 16'(cmd_valid), 16'd0);
        checkOutput("reset_err", 16'(frame_err), 16'd0);
        checkOutput("reset_busy", 16'(busy), 16'd0);
        checkOutput("pkg_clks_per_bit", 16'(clksPerBit(50_000_000, 9600)), 16'd5208);
        rst = 1'b0;
        driveBits(1'b1, 3 * CPB);

        // Short low pulse: START is entered, then abandoned at mid-bit.
        driveBits(1'b0, GLITCH_CLKS);
        checkOutput("glitch_busy", 16'(busy), 16'd1);
        driveBits(1'b1, 2 * CPB);
        checkOutput("glitch_idle", 16'(busy), 16'd0);
        checkOutput("glitch_cmd", 16'(arduino_command), 16'h00AA);
        checkOutput("glitch_no_valid", 16'(validCount), 16'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        // Last vector had a low stop bit; keep the line low as a break.
        driveBits(1'b0, 3 * CPB);
        checkOutput("break_busy", 16'(busy), 16'd1);
        checkOutput("break_err_count", 16'(errCount), 16'd1);
        checkOutput("break_cmd_kept", 16'(arduino_command), 16'h0081);
        checkOutput("table_valid_count", 16'(validCount), 16'd4);
        driveBits(1'b1, 5);
        checkOutput("recover_idle", 16'(busy), 16'd0);
        checkOutput("table_queue_empty", 16'(expQ.size()), 16'd0);
        driveBits(1'b1, CPB);

        // Abort 0x3C after four data bits with a reset.
        driveBits(1'b0, CPB);
        for (int i = 0; i < 4; i++) begin
            driveBits(((8'h3C >> i) & 8'h01) != 0, CPB);
        end
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midreset_cmd", 16'(arduino_command), 16'h00AA);
        checkOutput("midreset_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        driveBits(1'b1, 2 * CPB);
        v = '{8'hC3, 1'b1, 1'b0, 8'hC3};
        applyStimulus(v);
        driveBits(1'b1, 2 * CPB);
        checkOutput("final_cmd", 16'(arduino_command), 16'h00C3);
        checkOutput("final_queue_empty", 16'(expQ.size()), 16'd0);
        checkOutput("never_3c", 16'(seen3C), 16'd0);
        checkOutput("final_valid_count", 16'(validCount), 16'd5);
        checkOutput("final_err_count", 16'(errCount), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule

// File: doc/arduino_uart_rx.md
ARDUINO_UART_RX -- requirements
Module: arduino_uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 Parameter RESET_CMD, default 8'hAA, command value held after reset (neither 8'h00 nor 8'hFF).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 uart_rx  input  1  serial line from the Arduino, asynchronous to clk, idle high.
REQ-007 arduino_command  output  8  last correctly framed byte, held until the next good frame.
REQ-008 cmd_valid  output  1  one-cycle pulse when arduino_command is updated.
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 uart_rx SHALL pass through a 2-flop synchronizer before any use; all timing below is measured at the synchronizer output.
REQ-012 Bit period CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD using integer division (5208 at defaults); the half period SHALL equal CLKS_PER_BIT/2.
REQ-013 Frame format SHALL be 8N1: one low start bit, 8 data bits LSB first, one high stop bit.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, RECOVER.
REQ-015 IDLE -> START on a synchronized high-to-low transition.
REQ-016 START: at half period the line is resampled; low -> DATA with the bit counter cleared; high -> IDLE (glitch rejected, no output activity).
REQ-017 DATA: one sample every CLKS_PER_BIT (mid-bit), shifted in LSB first; after the 8th sample -> STOP.
REQ-018 STOP: the mid-bit sample high -> load the shift register into arduino_command, pulse cmd_valid, go to IDLE.
REQ-019 STOP: the mid-bit sample low -> pulse frame_err, keep arduino_command, go to RECOVER.
REQ-020 RECOVER -> IDLE only after the line is sampled high; it SHALL NOT start a new frame while the line is held low (break condition).
REQ-021 cmd_valid and frame_err SHALL be registered, SHALL be asserted in the cycle after the stop-bit sample, and SHALL never be asserted together.
REQ-022 A repeated identical byte SHALL still produce a cmd_valid pulse.
REQ-023 The block SHALL accept back-to-back frames: a start edge occurring immediately after the stop-bit sample SHALL be detected.
REQ-024 The bit-period counter SHALL be sized to $clog2(CLKS_PER_BIT) bits and SHALL NOT wrap within a bit.

Reset
REQ-025 While rst is high: FSM=IDLE, counters=0, shift register=0, synchronizer flops=1, arduino_command=RESET_CMD, cmd_valid=0, frame_err=0, busy=0.
REQ-026 A reset asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait for a new falling edge.

Structure
REQ-027 The state enum and the CLKS_PER_BIT computation SHALL live in the shared package uart_pkg.
REQ-028 The synchronizer SHALL be a separate sub-module sync_2ff (input, clk, rst, output; reset value 1).

Verification (CLK_FREQ=50_000_000, BAUD=9600)
REQ-029 Send 0x00 -> arduino_command=0x00, exactly one cmd_valid pulse, frame_err never high.
REQ-030 Send 0x00 then 0xFF back-to-back -> two cmd_valid pulses with final value 0xFF; send 0xFF again -> third pulse.
REQ-031 Drive a 1000-clock low glitch -> FSM returns to IDLE, no cmd_valid, arduino_command=0xAA.
REQ-032 Send 0x5A with a low stop bit, then hold the line low for 3 bit periods -> one frame_err pulse, command unchanged, busy high until the line goes high.
REQ-033 Assert rst after 4 data bits of 0x3C, then send 0xC3 -> arduino_command=0xC3, with 0x3C never appearing on the output.
